// File: rtl/sign_mag_pkg.sv
// Shared types and defaults for the serial two's-complement to sign-magnitude converter.
package sign_mag_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DefaultWidth = 4;

endpackage

// File: rtl/serial_negate_cell.sv
// One bit-slice of serial negation: copy bits through the first one, invert the rest.
// Holds the seen_one flag that marks whether a one has already passed.
module serial_negate_cell (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  input  logic b_i,
  input  logic sign_i,
  output logic out_bit_o,
  output logic seen_one_o
);

  logic seen_one_q, seen_one_d;

  always_comb begin
    out_bit_o  = sign_i ? (b_i ^ seen_one_q) : b_i;
    seen_one_d = seen_one_q;
    if (clear_i) begin
      seen_one_d = 1'b0;
    end else if (en_i) begin
      seen_one_d = seen_one_q | b_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

  assign seen_one_o = seen_one_q;

endmodule

// File: rtl/sign_mag_recover.sv
// Serial converter from a W-bit two's-complement result to sign and unsigned magnitude.
// Negative inputs are negated LSB first over W cycles; the result is held until taken.
module sign_mag_recover
  import sign_mag_pkg::*;
#(
  parameter int unsigned W = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [W-1:0] out_mag,
  output logic         busy
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  state_t state_q, state_d;

  logic [W-1:0]    sreg_q, sreg_d;
  logic [W-1:0]    mag_q, mag_d;
  logic            sign_q, sign_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic accept;
  logic shifting;
  logic last_bit;
  logic out_bit;
  logic seen_one;

  assign accept   = (state_q == IDLE) && in_valid;
  assign shifting = (state_q == SHIFT);
  assign last_bit = (cnt_q == CntLast);

  serial_negate_cell u_cell (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .en_i       (shifting),
    .b_i        (sreg_q[0]),
    .sign_i     (sign_q),
    .out_bit_o  (out_bit),
    .seen_one_o (seen_one)
  );

  // seen_one is consumed inside the cell; exposed only for debug visibility.
  logic unused_seen_one;
  assign unused_seen_one = seen_one;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      SHIFT:   busy = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: magnitude bits enter at the MSB so the LSB-first stream lands in order.
  always_comb begin
    sreg_d = sreg_q;
    mag_d  = mag_q;
    sign_d = sign_q;
    cnt_d  = cnt_q;
    if (accept) begin
      sreg_d = in_data;
      sign_d = in_data[W-1];
      cnt_d  = '0;
    end else if (shifting) begin
      sreg_d = {1'b0, sreg_q[W-1:1]};
      mag_d  = {out_bit, mag_q[W-1:1]};
      cnt_d  = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      mag_q  <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      mag_q  <= mag_d;
      sign_q <= sign_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_sign = sign_q;
  assign out_mag  = mag_q;

endmodule
